tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Time-division demultiplexer. It is the receive end of a TDM link whose transmit end selects one of CHANNELS sources per slot with 2:1/N:1 multiplexers.
- Accepts a serial word stream with a frame-sync marker and distributes slot k to output channel k.
- Presents each complete frame atomically on a registered parallel bus with a one-cycle valid pulse.
- Tracks frame alignment and flags sync errors.

Parameters:
- CHANNELS, 4, number of slots per frame (>=2)
- WIDTH, 8, bits per slot word

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  WIDTH  slot word from the TDM link
- din_valid  input  1  din carries a word this cycle
- frame_sync  input  1  marks din as slot 0 of a frame; qualified by din_valid
- dout  output  CHANNELS*WIDTH  frame output; channel k at bits [k*WIDTH +: WIDTH], channel 0 at LSBs
- dout_valid  output  1  one-cycle pulse when dout updates with a new complete frame
- locked  output  1  high while in RUN state
- slot_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (async assert, sync release):
  - dout=0, dout_valid=0, locked=0, slot_err=0.
  - Slot counter=0, shadow registers=0, state=HUNT.
- Only cycles with din_valid=1 are "accepted words". When din_valid=0, frame_sync is ignored and all state holds.
- Internal storage: shadow register bank (CHANNELS x WIDTH) and slot counter, width clog2(CHANNELS).
- HUNT state:
  - Accepted word with frame_sync=0: dropped, no error.
  - Accepted word with frame_sync=1: stored in shadow[0], slot=1, go to RUN.
- RUN state, accepted word, expected slot s:
  - frame_sync=0 and s!=0: store in shadow[s], s=s+1.
  - s==CHANNELS-1 (frame_sync=0): store the word and wrap s to 0. On the next clock edge, dout is loaded with the full shadow bank including this word, and dout_valid=1 for exactly one cycle. Latency from last-slot word accepted to dout_valid is 1 cycle.
  - frame_sync=1 and s==0: normal new frame; store in shadow[0], s=1.
  - frame_sync=1 and s!=0 (early sync): slot_err pulse. The partial frame is discarded with no dout_valid, the word is stored in shadow[0], s=1, and the state stays RUN.
  - frame_sync=0 and s==0 (missing sync): slot_err pulse, word dropped, go to HUNT, locked falls the next cycle.
- A frame-complete event and the next frame's slot-0 word on the following cycle are both handled; back-to-back frames with din_valid held high give one dout_valid every CHANNELS cycles.
- dout holds its last value between updates; it does not change on errors or HUNT entry.
- slot_err and dout_valid are never asserted in the same cycle.
- Reset mid-frame: partial frame lost, outputs return to reset values immediately.

Test Plan:
- Reset then 2 clean frames, CHANNELS=4, WIDTH=8: din_valid continuous, words 0x11(sync),0x22,0x33,0x44,0x55(sync),0x66,0x77,0x88 -> dout=0x44332211 with dout_valid one cycle after 0x44, then dout=0x88776655 with dout_valid one cycle after 0x88; locked=1 from the cycle after 0x11; slot_err never asserted.
- Gapped input: same first frame with din_valid=0 for 3 cycles between each word, and frame_sync=1 pulsed during a din_valid=0 cycle -> identical dout result, single dout_valid, no slot_err.
- Early sync: 0xA0(sync),0xA1,0xB0(sync),0xB1,0xB2,0xB3 -> slot_err pulse on 0xB0; no dout_valid for the A frame; dout=0xB3B2B1B0 with dout_valid after 0xB3.
- Missing sync: full frame, then 0xCC with frame_sync=0 -> slot_err pulse, locked=0 next cycle, dout unchanged; following words without sync are dropped until a sync word relocks.
- Hunt: words 0x01,0x02 with no sync after reset -> locked=0, no slot_err, no dout_valid.
- Reset mid-frame: assert rst_n=0 after 2 words of a frame -> dout=0, locked=0 immediately; after release, a fresh clean frame is output correctly.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: receive-side time-division demultiplexer.
// Collects CHANNELS serial slot words, aligned by a frame-sync marker, into a
// shadow bank. Each complete frame is presented on a registered parallel bus
// together with a one-cycle valid pulse. Loss of alignment is flagged with a
// one-cycle error pulse.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         slot word from the TDM link
//   din_valid   din carries a word this cycle
//   frame_sync  din is slot 0 of a frame (qualified by din_valid)
//   dout        last complete frame; channel k at [k*WIDTH +: WIDTH]
//   dout_valid  one-cycle pulse when dout takes a new frame
//   locked      high while frame alignment is held (RUN)
//   slot_err    one-cycle pulse on a framing violation
module tdm_demux #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            din,
  input  logic                        din_valid,
  input  logic                        frame_sync,
  output logic [CHANNELS*WIDTH-1:0]   dout,
  output logic                        dout_valid,
  output logic                        locked,
  output logic                        slot_err
);

  localparam int unsigned SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DW = CHANNELS * WIDTH;
  localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                          state, state_nxt;
  logic [SW-1:0]                   slot, slot_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0]  shadow, shadow_nxt;
  logic [DW-1:0]                   dout_nxt;
  logic                            dout_valid_nxt;
  logic                            slot_err_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, slot tracking, shadow capture and frame publication.
  always_comb begin
    state_nxt      = state;
    slot_nxt       = slot;
    shadow_nxt     = shadow;
    dout_nxt       = dout;
    dout_valid_nxt = 1'b0;
    slot_err_nxt   = 1'b0;

    if (din_valid) begin
      unique case (state)
        HUNT: begin
          // Non-sync words are discarded silently while searching.
          if (frame_sync) begin
            shadow_nxt[0] = din;
            slot_nxt      = SW'(1);
            state_nxt     = RUN;
          end
        end

        RUN: begin
          if (frame_sync) begin
            // Sync in mid-frame abandons the partial frame but stays aligned
            // to the new marker.
            slot_err_nxt  = (slot != '0);
            shadow_nxt[0] = din;
            slot_nxt      = SW'(1);
          end else if (slot == '0) begin
            // Slot 0 without a marker: alignment is lost.
            slot_err_nxt = 1'b1;
            state_nxt    = HUNT;
          end else begin
            shadow_nxt[slot] = din;
            if (slot == LAST_SLOT) begin
              // Publish from the updated bank so the last word lands in the
              // same edge that raises dout_valid.
              slot_nxt       = '0;
              dout_nxt       = shadow_nxt;
              dout_valid_nxt = 1'b1;
            end else begin
              slot_nxt = slot + SW'(1);
            end
          end
        end

        default: begin
          state_nxt = HUNT;
        end
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= '0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
      slot_err   <= 1'b0;
    end else begin
      slot       <= slot_nxt;
      shadow     <= shadow_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      locked     <= (state_nxt == RUN);
      slot_err   <= slot_err_nxt;
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux: directed scenarios plus randomized traffic checked
// by a queue-based reference model and a decoupled output monitor.
module tb_tdm_demux;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned DW = CH * W;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          frame_sync;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          locked;
  logic          slot_err;

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .slot_err   (slot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } frame_ev_t;

  typedef struct {
    int due;
    bit val;
  } lock_ev_t;

  frame_ev_t     frame_q[$];
  int            err_q[$];
  lock_ev_t      lock_q[$];
  logic [DW-1:0] exp_dout;
  bit            exp_locked;
  bit            mon_en;

  // Reference model state: words collected for the frame in progress.
  bit            m_locked;
  logic [W-1:0]  m_words[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Frame-level reference: a sync word always starts a new frame; a frame is
  // published once CH words have been gathered; an unsynced word at a frame
  // boundary loses lock.
  task automatic model(input logic [W-1:0] w, input logic fs, input logic v);
    logic [DW-1:0] fr;
    if (!v) return;
    if (fs) begin
      if (m_locked && m_words.size() != 0) err_q.push_back(cyc + 1);
      m_words.delete();
      m_words.push_back(w);
      if (!m_locked) begin
        m_locked = 1'b1;
        lock_q.push_back('{due: cyc + 1, val: 1'b1});
      end
    end else if (m_locked) begin
      if (m_words.size() == 0) begin
        err_q.push_back(cyc + 1);
        m_locked = 1'b0;
        lock_q.push_back('{due: cyc + 1, val: 1'b0});
      end else begin
        m_words.push_back(w);
        if (m_words.size() == CH) begin
          fr = '0;
          for (int k = 0; k < int'(CH); k++) fr[k*W +: W] = m_words[k];
          frame_q.push_back('{due: cyc + 1, data: fr});
          m_words.delete();
        end
      end
    end
  endtask

  task automatic send(input logic [W-1:0] w, input logic fs, input logic v);
    @(negedge clk);
    din        = w;
    frame_sync = fs;
    din_valid  = v;
    model(w, fs, v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send($urandom_range(0, 255), $urandom_range(0, 1), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("reset_dout", dout, '0);
    chk("reset_locked", locked, 0);
    chk("reset_dout_valid", dout_valid, 0);
    chk("reset_slot_err", slot_err, 0);
    frame_q.delete();
    err_q.delete();
    lock_q.delete();
    m_words.delete();
    m_locked   = 1'b0;
    exp_dout   = '0;
    exp_locked = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Output monitor: pops expected events when the DUT presents them.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      while (lock_q.size() != 0 && lock_q[0].due <= cyc) begin
        exp_locked = lock_q[0].val;
        void'(lock_q.pop_front());
      end
      chk("locked", locked, exp_locked);

      if (dout_valid) begin
        if (frame_q.size() == 0 || frame_q[0].due != cyc) begin
          flag("unexpected_dout_valid");
        end else begin
          chk("frame_data", dout, frame_q[0].data);
          exp_dout = frame_q[0].data;
          void'(frame_q.pop_front());
        end
      end else begin
        if (frame_q.size() != 0 && frame_q[0].due <= cyc) begin
          flag("missing_dout_valid");
          void'(frame_q.pop_front());
        end
        chk("dout_hold", dout, exp_dout);
      end

      if (slot_err) begin
        if (err_q.size() == 0 || err_q[0] != cyc) flag("unexpected_slot_err");
        else void'(err_q.pop_front());
      end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
        flag("missing_slot_err");
        void'(err_q.pop_front());
      end

      if (dout_valid && slot_err) flag("valid_and_err_together");
    end
  end

  task automatic send_gapped(input logic [W-1:0] w, input logic fs);
    send(w, fs, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int pos;
    logic fs_r;
    logic v_r;
    rst_n      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    mon_en     = 1'b0;
    exp_dout   = '0;
    exp_locked = 1'b0;
    m_locked   = 1'b0;

    do_reset();

    // Two clean frames back to back.
    send(8'h11, 1, 1); send(8'h22, 0, 1); send(8'h33, 0, 1); send(8'h44, 0, 1);
    send(8'h55, 1, 1); send(8'h66, 0, 1); send(8'h77, 0, 1); send(8'h88, 0, 1);
    idle(2);
    chk("clean_frames_dout", dout, 32'h88776655);
    chk("clean_frames_locked", locked, 1);

    // Gapped words with a stray sync on an idle cycle.
    do_reset();
    send_gapped(8'h11, 1); send_gapped(8'h22, 0); send_gapped(8'h33, 0); send_gapped(8'h44, 0);
    idle(2);
    chk("gapped_dout", dout, 32'h44332211);

    // Early sync discards the partial frame.
    send(8'hA0, 1, 1); send(8'hA1, 0, 1);
    send(8'hB0, 1, 1); send(8'hB1, 0, 1); send(8'hB2, 0, 1); send(8'hB3, 0, 1);
    idle(2);
    chk("early_sync_dout", dout, 32'hB3B2B1B0);

    // Missing sync drops lock; unsynced words ignored until a relock.
    send(8'hC0, 1, 1); send(8'hC1, 0, 1); send(8'hC2, 0, 1); send(8'hC3, 0, 1);
    send(8'hCC, 0, 1);
    idle(1);
    chk("missing_sync_locked", locked, 0);
    chk("missing_sync_dout", dout, 32'hC3C2C1C0);
    send(8'hDD, 0, 1); send(8'hEE, 0, 1);
    send(8'hD0, 1, 1); send(8'hD1, 0, 1); send(8'hD2, 0, 1); send(8'hD3, 0, 1);
    idle(2);
    chk("relock_dout", dout, 32'hD3D2D1D0);

    // Hunt after reset: no sync, no lock, no errors.
    do_reset();
    send(8'h01, 0, 1); send(8'h02, 0, 1);
    idle(2);
    chk("hunt_locked", locked, 0);
    chk("hunt_dout", dout, 0);

    // Reset in the middle of a frame.
    send(8'h91, 1, 1); send(8'h92, 0, 1);
    do_reset();
    send(8'h31, 1, 1); send(8'h32, 0, 1); send(8'h33, 0, 1); send(8'h34, 0, 1);
    idle(2);
    chk("post_reset_dout", dout, 32'h34333231);

    // Randomized traffic with occasional misplaced or missing syncs.
    pos = 0;
    for (int i = 0; i < 4000; i++) begin
      v_r  = ($urandom_range(0, 3) != 0);
      fs_r = (pos == 0) ^ ($urandom_range(0, 24) == 0);
      send(8'($urandom), fs_r, v_r);
      if (v_r) pos = (fs_r ? 1 : pos + 1) % int'(CH);
    end
    idle(5);
    chk("frame_queue_drained", 64'(frame_q.size()), 0);
    chk("err_queue_drained", 64'(err_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
